// File: rtl/bus_arbiter_if.sv
// Handshake bundle between the bus masters / split slave and the bus arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 2
) ();
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] m_req;
  logic [NUM_MASTERS-1:0] m_grant;
  logic [IDX_W-1:0]       owner;
  logic                   bus_busy;
  logic                   s_split;
  logic                   s_split_ready;
  logic                   split_pending;
  logic                   timeout;

  modport master (
    output m_req,
    output s_split,
    output s_split_ready,
    input  m_grant,
    input  owner,
    input  bus_busy,
    input  split_pending,
    input  timeout
  );

  modport slave (
    input  m_req,
    input  s_split,
    input  s_split_ready,
    output m_grant,
    output owner,
    output bus_busy,
    output split_pending,
    output timeout
  );
endinterface

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: one owner at a time, split-transaction parking/resume and hold timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed priority.
module bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic         clk,
  input  logic         rstn,
  bus_arbiter_if.slave bus
);
  localparam int               IDX_W   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  // First set bit of elig searching upward from start, wrapping; returns {found, index}.
  function automatic logic [IDX_W:0] pick_first(
    input logic [NUM_MASTERS-1:0] elig,
    input logic [IDX_W-1:0]       start
  );
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] jj;
    int               j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      j = int'(start) + i;
      if (j >= NUM_MASTERS) begin
        j = j - NUM_MASTERS;
      end
      jj = IDX_W'(j);
      if (!found && elig[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
    return {found, idx};
  endfunction

  state_t                 state_r, state_s;
  logic [NUM_MASTERS-1:0] grant_r, grant_s;
  logic [IDX_W-1:0]       owner_r, owner_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic [IDX_W-1:0]       parked_r, parked_s;
  logic                   pending_r, pending_s;
  logic                   resume_r, resume_s;
  logic                   timeout_r, timeout_s;
  logic                   busy_r;
`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]       rr_ptr_r, rr_ptr_s;
`endif

  logic [NUM_MASTERS-1:0] parked_mask_s;
  logic [NUM_MASTERS-1:0] elig_s;
  logic [IDX_W:0]         pick_s;
  logic                   pick_found_s;
  logic [IDX_W-1:0]       pick_idx_s;

  assign parked_mask_s = NUM_MASTERS'(1) << parked_r;
  assign pick_found_s  = pick_s[IDX_W];
  assign pick_idx_s    = pick_s[IDX_W-1:0];

  // Candidate for a normal (non-resume) grant; a parked master stays masked.
  always_comb begin
    if (pending_r) begin
      elig_s = bus.m_req & ~parked_mask_s;
    end else begin
      elig_s = bus.m_req;
    end
`ifdef ARB_ROUND_ROBIN_EN
    pick_s = pick_first(elig_s, rr_ptr_r);
`else
    pick_s = pick_first(elig_s, '0);
`endif
  end

  // Next-state, grant and split/timeout bookkeeping.
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    owner_s   = owner_r;
    cnt_s     = cnt_r;
    parked_s  = parked_r;
    pending_s = pending_r;
    resume_s  = resume_r;
    timeout_s = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_s  = rr_ptr_r;
`endif

    // A parked master that gives up its request abandons the split outright.
    if (pending_r && !bus.m_req[parked_r]) begin
      pending_s = 1'b0;
      resume_s  = 1'b0;
    end else if (pending_r && bus.s_split_ready) begin
      resume_s = 1'b1;
    end else begin
      resume_s = resume_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (resume_r && pending_r && bus.m_req[parked_r]) begin
          grant_s   = parked_mask_s;
          owner_s   = parked_r;
          cnt_s     = '0;
          pending_s = 1'b0;
          resume_s  = 1'b0;
          state_s   = ST_GRANT;
        end else if (pick_found_s) begin
          grant_s = NUM_MASTERS'(1) << pick_idx_s;
          owner_s = pick_idx_s;
          cnt_s   = '0;
          state_s = ST_GRANT;
`ifdef ARB_ROUND_ROBIN_EN
          if (pick_idx_s == IDX_W'(NUM_MASTERS - 1)) begin
            rr_ptr_s = '0;
          end else begin
            rr_ptr_s = pick_idx_s + IDX_W'(1);
          end
`endif
        end else begin
          grant_s = '0;
          state_s = ST_IDLE;
        end
      end

      ST_GRANT: begin
        cnt_s = cnt_r + CNT_W'(1);
        // Priority on a shared cycle: release, then split, then timeout.
        if (!bus.m_req[owner_r]) begin
          grant_s = '0;
          state_s = ST_TURN;
        end else if (bus.s_split && !pending_r) begin
          parked_s  = owner_r;
          pending_s = 1'b1;
          resume_s  = 1'b0;
          grant_s   = '0;
          state_s   = ST_TURN;
        end else if (TO_EN && (cnt_r == TO_LAST)) begin
          grant_s   = '0;
          timeout_s = 1'b1;
          state_s   = ST_TURN;
        end else begin
          state_s = ST_GRANT;
        end
      end

      ST_TURN: begin
        grant_s = '0;
        state_s = ST_IDLE;
      end

      default: begin
        grant_s = '0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      grant_r   <= '0;
      owner_r   <= '0;
      cnt_r     <= '0;
      parked_r  <= '0;
      pending_r <= 1'b0;
      resume_r  <= 1'b0;
      timeout_r <= 1'b0;
      busy_r    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_r  <= '0;
`endif
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      owner_r   <= owner_s;
      cnt_r     <= cnt_s;
      parked_r  <= parked_s;
      pending_r <= pending_s;
      resume_r  <= resume_s;
      timeout_r <= timeout_s;
      busy_r    <= |grant_s;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_r  <= rr_ptr_s;
`endif
    end
  end

  assign bus.m_grant       = grant_r;
  assign bus.owner         = owner_r;
  assign bus.bus_busy      = busy_r;
  assign bus.split_pending = pending_r;
  assign bus.timeout       = timeout_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter (2 masters, 8-cycle timeout, fixed priority build).
module tb_bus_arbiter;
  logic clk;
  logic rstn;
  int   errors;
  int   checks;

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } sb_t;

  sb_t sb_q[$];

  bus_arbiter_if #(.NUM_MASTERS(2)) bus_if ();

  bus_arbiter #(
    .NUM_MASTERS   (2),
    .TIMEOUT_CYCLES(8),
    .CNT_W         (4)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output snapshot {m_grant, owner, bus_busy, split_pending, timeout}.
  function automatic logic [5:0] ex(input logic [1:0] g, input logic o, input logic p, input logic t);
    return {g, o, |g, p, t};
  endfunction

  // Drive one cycle of inputs, queue the expected post-edge outputs, then check.
  task automatic cyc(input string tag, input logic [1:0] req, input logic spl,
                     input logic rdy, input logic rst_v, input logic [5:0] exp);
    sb_t        e;
    logic [5:0] got;
    bus_if.m_req         = req;
    bus_if.s_split       = spl;
    bus_if.s_split_ready = rdy;
    rstn                 = rst_v;
    sb_q.push_back('{tag, exp});
    @(posedge clk);
    #1;
    got = {bus_if.m_grant, bus_if.owner, bus_if.bus_busy, bus_if.split_pending, bus_if.timeout};
    e   = sb_q.pop_front();
    checks++;
    assert (got === e.exp) else begin
      errors++;
      $error("FAIL %s observed={grant,owner,busy,pend,tmo}=%b expected=%b", e.tag, got, e.exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus_if.m_req         = 2'b00;
    bus_if.s_split       = 1'b0;
    bus_if.s_split_ready = 1'b0;
    rstn                 = 1'b0;

    cyc("reset0", 2'b00, 1'b0, 1'b0, 1'b0, ex(2'b00, 1'b0, 1'b0, 1'b0));
    cyc("reset1", 2'b00, 1'b0, 1'b0, 1'b0, ex(2'b00, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++) cyc("idle", 2'b00, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b0, 1'b0));
    cyc("split_in_idle", 2'b00, 1'b1, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b0, 1'b0));

    // Single request: one-cycle grant latency, release, TURN, IDLE.
    cyc("t1_grant", 2'b01, 1'b0, 1'b0, 1'b1, ex(2'b01, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) cyc("t1_hold", 2'b01, 1'b0, 1'b0, 1'b1, ex(2'b01, 1'b0, 1'b0, 1'b0));
    cyc("t1_release", 2'b00, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b0, 1'b0));
    cyc("t1_idle", 2'b00, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b0, 1'b0));

    // Contention: lowest index first, dead cycles between owners.
    cyc("t2_contend", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b01, 1'b0, 1'b0, 1'b0));
    cyc("t2_m0_hold", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b01, 1'b0, 1'b0, 1'b0));
    cyc("t2_m0_rel", 2'b10, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b0, 1'b0));
    cyc("t2_turn", 2'b10, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b0, 1'b0));
    cyc("t2_m1_grant", 2'b10, 1'b0, 1'b0, 1'b1, ex(2'b10, 1'b1, 1'b0, 1'b0));
    cyc("t2_m1_hold", 2'b10, 1'b0, 1'b0, 1'b1, ex(2'b10, 1'b1, 1'b0, 1'b0));
    cyc("t2_no_preempt", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b10, 1'b1, 1'b0, 1'b0));
    cyc("t2_m1_rel", 2'b01, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b1, 1'b0, 1'b0));
    cyc("t2_turn2", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b1, 1'b0, 1'b0));
    cyc("t2_round2", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b01, 1'b0, 1'b0, 1'b0));
    cyc("t2_rel_all", 2'b00, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b0, 1'b0));
    cyc("t2_idle", 2'b00, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b0, 1'b0));

    // Split: park M1, M0 served, ready pulse, M1 resumes ahead of M0.
    cyc("t3_m1_grant", 2'b10, 1'b0, 1'b0, 1'b1, ex(2'b10, 1'b1, 1'b0, 1'b0));
    cyc("t3_m1_hold", 2'b10, 1'b0, 1'b0, 1'b1, ex(2'b10, 1'b1, 1'b0, 1'b0));
    cyc("t3_split", 2'b10, 1'b1, 1'b0, 1'b1, ex(2'b00, 1'b1, 1'b1, 1'b0));
    cyc("t3_turn", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b1, 1'b1, 1'b0));
    cyc("t3_m0_grant", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b01, 1'b0, 1'b1, 1'b0));
    cyc("t3_m0_hold", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b01, 1'b0, 1'b1, 1'b0));
    cyc("t3_ready", 2'b11, 1'b0, 1'b1, 1'b1, ex(2'b01, 1'b0, 1'b1, 1'b0));
    cyc("t3_m0_hold2", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b01, 1'b0, 1'b1, 1'b0));
    cyc("t3_m0_rel", 2'b10, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b1, 1'b0));
    cyc("t3_turn2", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b1, 1'b0));
    cyc("t3_resume", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b10, 1'b1, 1'b0, 1'b0));
    cyc("t3_m1_hold2", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b10, 1'b1, 1'b0, 1'b0));
    cyc("t3_m1_rel", 2'b01, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b1, 1'b0, 1'b0));

    // Timeout after eight held cycles, then re-grant.
    cyc("t4_turn", 2'b01, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b1, 1'b0, 1'b0));
    cyc("t4_grant", 2'b01, 1'b0, 1'b0, 1'b1, ex(2'b01, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 7; k++) cyc("t4_hold", 2'b01, 1'b0, 1'b0, 1'b1, ex(2'b01, 1'b0, 1'b0, 1'b0));
    cyc("t4_timeout", 2'b01, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b0, 1'b1));
    cyc("t4_pulse_end", 2'b01, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b0, 1'b0));
    cyc("t4_regrant", 2'b01, 1'b0, 1'b0, 1'b1, ex(2'b01, 1'b0, 1'b0, 1'b0));

    // Reset mid-grant with M0 parked; M0 must not stay masked afterwards.
    cyc("t5_split", 2'b01, 1'b1, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b1, 1'b0));
    cyc("t5_turn", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b1, 1'b0));
    cyc("t5_m1_grant", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b10, 1'b1, 1'b1, 1'b0));
    cyc("t5_m1_hold", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b10, 1'b1, 1'b1, 1'b0));
    cyc("t5_reset", 2'b11, 1'b0, 1'b0, 1'b0, ex(2'b00, 1'b0, 1'b0, 1'b0));
    cyc("t5_after_rst", 2'b01, 1'b0, 1'b0, 1'b1, ex(2'b01, 1'b0, 1'b0, 1'b0));
    cyc("t5_rel", 2'b00, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b0, 1'b0));
    cyc("t5_idle", 2'b00, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b0, 1'b0));

    // Second split ignored, abandoned split, release beats split.
    cyc("t6_m0_grant", 2'b01, 1'b0, 1'b0, 1'b1, ex(2'b01, 1'b0, 1'b0, 1'b0));
    cyc("t6_split", 2'b01, 1'b1, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b1, 1'b0));
    cyc("t6_turn", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b0, 1'b1, 1'b0));
    cyc("t6_m1_grant", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b10, 1'b1, 1'b1, 1'b0));
    cyc("t6_split2_ign", 2'b11, 1'b1, 1'b0, 1'b1, ex(2'b10, 1'b1, 1'b1, 1'b0));
    cyc("t6_m1_hold", 2'b11, 1'b0, 1'b0, 1'b1, ex(2'b10, 1'b1, 1'b1, 1'b0));
    cyc("t6_abandon", 2'b10, 1'b0, 1'b0, 1'b1, ex(2'b10, 1'b1, 1'b0, 1'b0));
    cyc("t6_ready_ign", 2'b10, 1'b0, 1'b1, 1'b1, ex(2'b10, 1'b1, 1'b0, 1'b0));
    cyc("t6_rel_split", 2'b00, 1'b1, 1'b0, 1'b1, ex(2'b00, 1'b1, 1'b0, 1'b0));
    cyc("t6_idle", 2'b00, 1'b0, 1'b0, 1'b1, ex(2'b00, 1'b1, 1'b0, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
